// File: rtl/pid_scheduler.sv
// -----------------------------------------------------------------------------
// pid_scheduler
//
// Time-multiplexes one shared PID engine across NUM_CH servo channels. A
// free-running divider produces a sample tick every TICK_DIV clocks; each tick
// starts a frame. The frame walks the enabled channels in ascending order,
// hands each one's operands and stored integral/last-error to the engine,
// waits for its acknowledge (bounded by ACK_TIMEOUT), then commits the clamped
// results. Disabled channels are parked at DUTY_CENTER with cleared state.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   setpoint_in           per-channel target, ch k at [12k+11:12k]
//   feedback_in           per-channel measured position, same packing
//   enable_mask           channel enables, sampled at frame start
//   pid_req               operand-valid request to the PID engine
//   pid_ch                channel currently being computed
//   pid_setpoint          setpoint operand for pid_ch
//   pid_feedback          feedback operand for pid_ch
//   pid_integral_in       stored integral for pid_ch
//   pid_last_error_in     stored last error for pid_ch
//   pid_ack               engine result valid (only honoured while pid_req=1)
//   pid_duty              engine duty result
//   pid_integral_out      engine updated integral
//   pid_last_error_out    engine updated last error
//   duty_out              per-channel PWM duty, ch k at [18k+17:18k]
//   busy                  frame in progress
//   frame_done            one-cycle pulse at frame end
//   overrun               one-cycle pulse when a tick arrives mid-frame
//   fault                 sticky per-channel acknowledge-timeout flags
// -----------------------------------------------------------------------------
module pid_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int TICK_DIV    = 1000000,
    parameter int ACK_TIMEOUT = 64,
    parameter int INT_LIM     = 1048576,
    parameter int DUTY_CENTER = 75000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*12-1:0]     setpoint_in,
    input  logic [NUM_CH*12-1:0]     feedback_in,
    input  logic [NUM_CH-1:0]        enable_mask,
    output logic                     pid_req,
    output logic [1:0]               pid_ch,
    output logic [11:0]              pid_setpoint,
    output logic [11:0]              pid_feedback,
    output logic signed [31:0]       pid_integral_in,
    output logic signed [31:0]       pid_last_error_in,
    input  logic                     pid_ack,
    input  logic [17:0]              pid_duty,
    input  logic signed [31:0]       pid_integral_out,
    input  logic signed [31:0]       pid_last_error_out,
    output logic [NUM_CH*18-1:0]     duty_out,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun,
    output logic [NUM_CH-1:0]        fault
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WT_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [WT_W-1:0]    WT_LAST  = WT_W'(ACK_TIMEOUT - 1);
    localparam logic [17:0]        DUTY_C   = 18'(DUTY_CENTER);
    localparam logic [17:0]        DUTY_MIN = 18'd50000;
    localparam logic [17:0]        DUTY_MAX = 18'd100000;
    localparam logic signed [31:0] INT_HI   = 32'(INT_LIM);
    localparam logic signed [31:0] INT_LO   = 32'(-INT_LIM);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REQ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0]       mask_q, mask_d;
    logic [NUM_CH-1:0]       served_q, served_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [11:0]             sp_q, sp_d;
    logic [11:0]             fb_q, fb_d;
    logic [WT_W-1:0]         wcnt_q, wcnt_d;
    logic [17:0]             rduty_q, rduty_d;
    logic signed [31:0]      rint_q, rint_d;
    logic signed [31:0]      rlerr_q, rlerr_d;
    logic [NUM_CH*18-1:0]    duty_q, duty_d;
    logic [NUM_CH*32-1:0]    integ_q, integ_d;
    logic [NUM_CH*32-1:0]    lerr_q, lerr_d;
    logic [NUM_CH-1:0]       fault_q, fault_d;

    logic                    tick;
    logic                    found;
    logic [CH_W-1:0]         sel;

    function automatic logic [17:0] clamp_duty(input logic [17:0] v);
        if (v < DUTY_MIN) begin
            return DUTY_MIN;
        end else if (v > DUTY_MAX) begin
            return DUTY_MAX;
        end
        return v;
    endfunction

    function automatic logic signed [31:0] clamp_int(input logic signed [31:0] v);
        if (v > INT_HI) begin
            return INT_HI;
        end else if (v < INT_LO) begin
            return INT_LO;
        end
        return v;
    endfunction

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        mask_d   = mask_q;
        served_d = served_q;
        ch_d     = ch_q;
        sp_d     = sp_q;
        fb_d     = fb_q;
        wcnt_d   = wcnt_q;
        rduty_d  = rduty_q;
        rint_d   = rint_q;
        rlerr_d  = rlerr_q;
        duty_d   = duty_q;
        integ_d  = integ_q;
        lerr_d   = lerr_q;
        fault_d  = fault_q;
        found    = 1'b0;
        sel      = '0;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    mask_d   = enable_mask;
                    served_d = '0;
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                // Parking disabled channels on every SCAN is idempotent, so it
                // needs no extra state to run only once per frame.
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (!mask_q[i]) begin
                        duty_d[18*i +: 18]  = DUTY_C;
                        integ_d[32*i +: 32] = '0;
                        lerr_d[32*i +: 32]  = '0;
                    end else if (!served_q[i] && !found) begin
                        found = 1'b1;
                        sel   = CH_W'(i);
                    end
                end
                if (found) begin
                    ch_d          = sel;
                    served_d[sel] = 1'b1;
                    // Operands are latched so they stay stable for the whole
                    // request even if the inputs move.
                    sp_d          = setpoint_in[12*sel +: 12];
                    fb_d          = feedback_in[12*sel +: 12];
                    state_d       = REQ;
                end else begin
                    state_d = DONE;
                end
            end

            REQ: begin
                wcnt_d = '0;
                if (pid_ack) begin
                    rduty_d = clamp_duty(pid_duty);
                    rint_d  = clamp_int(pid_integral_out);
                    rlerr_d = pid_last_error_out;
                    state_d = WRITE;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (pid_ack) begin
                    rduty_d = clamp_duty(pid_duty);
                    rint_d  = clamp_int(pid_integral_out);
                    rlerr_d = pid_last_error_out;
                    state_d = WRITE;
                end else if (wcnt_q == WT_LAST) begin
                    // Timeout: keep the duty, drop the integral, flag the channel.
                    fault_d[ch_q]          = 1'b1;
                    integ_d[32*ch_q +: 32] = '0;
                    state_d                = SCAN;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end

            WRITE: begin
                duty_d[18*ch_q +: 18]  = rduty_q;
                integ_d[32*ch_q +: 32] = rint_q;
                lerr_d[32*ch_q +: 32]  = rlerr_q;
                state_d                = SCAN;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            served_q <= '0;
            ch_q     <= '0;
            sp_q     <= '0;
            fb_q     <= '0;
            wcnt_q   <= '0;
            rduty_q  <= DUTY_C;
            rint_q   <= '0;
            rlerr_q  <= '0;
            duty_q   <= {NUM_CH{DUTY_C}};
            integ_q  <= '0;
            lerr_q   <= '0;
            fault_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            served_q <= served_d;
            ch_q     <= ch_d;
            sp_q     <= sp_d;
            fb_q     <= fb_d;
            wcnt_q   <= wcnt_d;
            rduty_q  <= rduty_d;
            rint_q   <= rint_d;
            rlerr_q  <= rlerr_d;
            duty_q   <= duty_d;
            integ_q  <= integ_d;
            lerr_q   <= lerr_d;
            fault_q  <= fault_d;
        end
    end

    assign pid_req           = (state_q == REQ) || (state_q == WAIT);
    assign pid_ch            = 2'(ch_q);
    assign pid_setpoint      = sp_q;
    assign pid_feedback      = fb_q;
    assign pid_integral_in   = $signed(integ_q[32*ch_q +: 32]);
    assign pid_last_error_in = $signed(lerr_q[32*ch_q +: 32]);
    assign duty_out          = duty_q;
    assign busy              = (state_q != IDLE);
    assign frame_done        = (state_q == DONE);
    // A tick seen while a frame is running is dropped; this is its only trace.
    assign overrun           = tick && (state_q != IDLE);
    assign fault             = fault_q;

endmodule

// File: tb/tb_pid_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pid_scheduler
//
// Bench for pid_scheduler with TICK_DIV=16. A behavioural PID engine answers
// each request after a programmable delay with programmable results. Each row
// of the frame table configures one frame and lists the operands expected at
// every request (scoreboard) and the duty/fault/overrun state after the frame.
// -----------------------------------------------------------------------------
module tb_pid_scheduler;

    logic               clk;
    logic               rst_n;
    logic [47:0]        setpoint_in;
    logic [47:0]        feedback_in;
    logic [3:0]         enable_mask;
    logic               pid_req;
    logic [1:0]         pid_ch;
    logic [11:0]        pid_setpoint;
    logic [11:0]        pid_feedback;
    logic signed [31:0] pid_integral_in;
    logic signed [31:0] pid_last_error_in;
    logic               pid_ack;
    logic [17:0]        pid_duty;
    logic signed [31:0] pid_integral_out;
    logic signed [31:0] pid_last_error_out;
    logic [71:0]        duty_out;
    logic               busy;
    logic               frame_done;
    logic               overrun;
    logic [3:0]         fault;

    pid_scheduler #(
        .NUM_CH      (4),
        .TICK_DIV    (16),
        .ACK_TIMEOUT (64),
        .INT_LIM     (1048576),
        .DUTY_CENTER (75000)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .setpoint_in        (setpoint_in),
        .feedback_in        (feedback_in),
        .enable_mask        (enable_mask),
        .pid_req            (pid_req),
        .pid_ch             (pid_ch),
        .pid_setpoint       (pid_setpoint),
        .pid_feedback       (pid_feedback),
        .pid_integral_in    (pid_integral_in),
        .pid_last_error_in  (pid_last_error_in),
        .pid_ack            (pid_ack),
        .pid_duty           (pid_duty),
        .pid_integral_out   (pid_integral_out),
        .pid_last_error_out (pid_last_error_out),
        .duty_out           (duty_out),
        .busy               (busy),
        .frame_done         (frame_done),
        .overrun            (overrun),
        .fault              (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]   mask;
        int           delay;
        bit           noack1;
        bit           flip;
        int           duty;
        int           integ;
        int           lerr;
        logic [127:0] exp_int;
        logic [127:0] exp_lerr;
        logic [71:0]  exp_duty;
        logic [3:0]   exp_fault;
        int           exp_ovr;
        int           rl_ch;
        int           rl_exp;
    } row_t;

    typedef struct {
        int          ch;
        logic [31:0] int_in;
        logic [31:0] lerr_in;
    } sb_t;

    int   total = 0;
    int   bad   = 0;
    sb_t  sb[$];
    int   ovr_cnt = 0;
    int   req_len[4];
    row_t rows[10];

    int   eng_delay  = 3;
    bit   eng_noack1 = 1'b0;
    int   eng_duty   = 0;
    int   eng_int    = 0;
    int   eng_lerr   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [127:0] p32(input int a0, input int a1, input int a2, input int a3);
        return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    function automatic logic [71:0] p18(input int a0, input int a1, input int a2, input int a3);
        return {18'(a3), 18'(a2), 18'(a1), 18'(a0)};
    endfunction

    function automatic row_t mk_row(input logic [3:0] mask, input int delay, input bit noack1,
                                    input bit flip, input int duty, input int integ, input int lerr,
                                    input logic [127:0] ei, input logic [127:0] el,
                                    input logic [71:0] ed, input logic [3:0] ef, input int eo,
                                    input int rlc, input int rle);
        row_t r;
        r.mask = mask; r.delay = delay; r.noack1 = noack1; r.flip = flip;
        r.duty = duty; r.integ = integ; r.lerr = lerr;
        r.exp_int = ei; r.exp_lerr = el; r.exp_duty = ed; r.exp_fault = ef;
        r.exp_ovr = eo; r.rl_ch = rlc; r.rl_exp = rle;
        return r;
    endfunction

    task automatic configure(input row_t r);
        sb_t e;
        enable_mask = r.mask;
        eng_delay   = r.delay;
        eng_noack1  = r.noack1;
        eng_duty    = r.duty;
        eng_int     = r.integ;
        eng_lerr    = r.lerr;
        for (int unsigned c = 0; c < 4; c++) begin
            if (r.mask[c]) begin
                e.ch      = int'(c);
                e.int_in  = r.exp_int[32*c +: 32];
                e.lerr_in = r.exp_lerr[32*c +: 32];
                sb.push_back(e);
            end
        end
    endtask

    // Behavioural PID engine.
    initial begin
        int ewc;
        ewc                = 0;
        pid_ack            = 1'b0;
        pid_duty           = '0;
        pid_integral_out   = '0;
        pid_last_error_out = '0;
        forever begin
            @(negedge clk);
            pid_ack = 1'b0;
            if (rst_n && pid_req) begin
                ewc++;
                if (ewc >= eng_delay && !(eng_noack1 && pid_ch == 2'd1)) begin
                    pid_ack            = 1'b1;
                    pid_duty           = 18'(eng_duty);
                    pid_integral_out   = eng_int;
                    pid_last_error_out = eng_lerr;
                    ewc                = 0;
                end
            end else begin
                ewc = 0;
            end
        end
    end

    // Request monitor: pops the scoreboard on each new request.
    initial begin
        bit  req_prev;
        int  rlen;
        int  rch;
        sb_t e;
        req_prev = 1'b0;
        rlen     = 0;
        rch      = 0;
        for (int unsigned c = 0; c < 4; c++) req_len[c] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 1'b0;
                rlen     = 0;
            end else begin
                if (overrun) ovr_cnt++;
                if (pid_req && !req_prev) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected_req: got ch %0d want no request", pid_ch);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_ch", 32'(pid_ch), e.ch);
                        chk("sb_setpoint", 32'(pid_setpoint), 100 + e.ch);
                        chk("sb_feedback", 32'(pid_feedback), 200 + e.ch);
                        chk("sb_integral_in", pid_integral_in, e.int_in);
                        chk("sb_last_error_in", pid_last_error_in, e.lerr_in);
                    end
                    rlen = 0;
                    rch  = int'(pid_ch);
                end
                if (pid_req) begin
                    rlen++;
                end else if (req_prev) begin
                    req_len[rch] = rlen;
                end
                req_prev = pid_req;
            end
        end
    end

    initial begin
        int n;
        int ovr_base;

        rows[0] = mk_row(4'hF, 3, 0, 0, 80000, 100, 11, p32(0, 0, 0, 0), p32(0, 0, 0, 0),
                         p18(80000, 80000, 80000, 80000), 4'h0, 1, 0, 3);
        rows[1] = mk_row(4'h5, 3, 0, 0, 60000, 200, 22, p32(100, 0, 100, 0), p32(11, 0, 11, 0),
                         p18(60000, 75000, 60000, 75000), 4'h0, 0, 0, 3);
        rows[2] = mk_row(4'hF, 3, 0, 0, 120000, 2000000, -33, p32(200, 0, 200, 0), p32(22, 0, 22, 0),
                         p18(100000, 100000, 100000, 100000), 4'h0, 1, 3, 3);
        rows[3] = mk_row(4'h3, 3, 0, 0, 40000, -5000000, 44, p32(1048576, 1048576, 0, 0),
                         p32(-33, -33, 0, 0), p18(50000, 50000, 75000, 75000), 4'h0, 0, 1, 3);
        rows[4] = mk_row(4'h7, 3, 1, 0, 70000, 300, 66, p32(-1048576, -1048576, 0, 0),
                         p32(44, 44, 0, 0), p18(70000, 50000, 70000, 75000), 4'h2, 4, 1, 65);
        rows[5] = mk_row(4'hF, 3, 0, 0, 90000, 7, 55, p32(300, 0, 300, 0), p32(66, 44, 66, 0),
                         p18(90000, 90000, 90000, 90000), 4'h2, 1, 2, 3);
        rows[6] = mk_row(4'h0, 3, 0, 0, 80000, 1, 1, p32(0, 0, 0, 0), p32(0, 0, 0, 0),
                         p18(75000, 75000, 75000, 75000), 4'h2, 0, 0, 0);
        rows[7] = mk_row(4'h1, 20, 0, 0, 65000, 5, 1, p32(0, 0, 0, 0), p32(0, 0, 0, 0),
                         p18(65000, 75000, 75000, 75000), 4'h2, 1, 0, 20);
        rows[8] = mk_row(4'hF, 3, 0, 1, 85000, 9, 2, p32(5, 0, 0, 0), p32(1, 0, 0, 0),
                         p18(85000, 85000, 85000, 85000), 4'h2, 1, 3, 3);
        rows[9] = mk_row(4'h0, 3, 0, 0, 80000, 1, 1, p32(0, 0, 0, 0), p32(0, 0, 0, 0),
                         p18(75000, 75000, 75000, 75000), 4'h2, 0, 0, 0);

        rst_n       = 1'b0;
        enable_mask = '0;
        setpoint_in = {12'd103, 12'd102, 12'd101, 12'd100};
        feedback_in = {12'd203, 12'd202, 12'd201, 12'd200};
        configure(rows[0]);

        repeat (3) @(negedge clk);
        chk("rst_pid_req", 32'(pid_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_integral_in", pid_integral_in, 0);
        for (int unsigned c = 0; c < 4; c++) chk("rst_duty", 32'(duty_out[18*c +: 18]), 75000);

        // First request lands 17 edges after release: tick after edge 15,
        // SCAN after edge 16, REQ after edge 17.
        rst_n = 1'b1;
        n = 0;
        while (!pid_req && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 15) chk("busy_before_tick", 32'(busy), 0);
            if (n == 16) chk("busy_after_tick", 32'(busy), 1);
        end
        chk("first_req_latency", n, 17);
        ovr_base = ovr_cnt;

        for (int unsigned i = 0; i < 10; i++) begin
            if (rows[i].flip) begin
                n = 0;
                while (!pid_req && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                chk("flip_req_seen", 32'(pid_req), 1);
                enable_mask = 4'h0;
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!frame_done && n < 2000);
            chk("frame_done_seen", 32'(frame_done), 1);
            for (int unsigned c = 0; c < 4; c++) begin
                chk("frame_duty", 32'(duty_out[18*c +: 18]), 32'(rows[i].exp_duty[18*c +: 18]));
            end
            chk("frame_fault", 32'(fault), 32'(rows[i].exp_fault));
            chk("frame_overruns", ovr_cnt - ovr_base, rows[i].exp_ovr);
            chk("sb_drained", sb.size(), 0);
            if (rows[i].rl_exp != 0) chk("req_length", req_len[rows[i].rl_ch], rows[i].rl_exp);
            ovr_base = ovr_cnt;
            if (i < 9) configure(rows[i+1]);
            @(negedge clk);
            chk("frame_done_pulse", 32'(frame_done), 0);
            chk("busy_after_done", 32'(busy), 0);
        end

        // Reset with a request in flight.
        configure(mk_row(4'hF, 3, 0, 0, 80000, 1, 1, p32(0, 0, 0, 0), p32(0, 0, 0, 0),
                         p18(0, 0, 0, 0), 4'h0, 0, 0, 0));
        sb.delete();
        begin
            sb_t e;
            e.ch = 0; e.int_in = '0; e.lerr_in = '0;
            sb.push_back(e);
        end
        n = 0;
        while (!pid_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_req", 32'(pid_req), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pid_req", 32'(pid_req), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_fault", 32'(fault), 0);
        for (int unsigned c = 0; c < 4; c++) chk("async_rst_duty", 32'(duty_out[18*c +: 18]), 75000);
        sb.delete();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
